// File: rtl/DataTypes_pkg.sv
// Shared datapath types for the immediate generator.
// Immediate select encoding and skid buffer states.
package DataTypes_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    IMM_TypeI  = 4'd0,
    IMM_TypeIu = 4'd1,
    IMM_TypeS  = 4'd2,
    IMM_TypeB  = 4'd3,
    IMM_TypeBu = 4'd4,
    IMM_TypeU  = 4'd5,
    IMM_TypeJ  = 4'd6,
    IMM_TypeZ  = 4'd7,
    IMM_TypeSh = 4'd8
  } IMM_t;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_st_t;

endpackage

// File: rtl/imm_extend_pipe_comb.sv
// Pure field select and extension of an RV immediate.
// Unknown selects yield zero with err raised.
module imm_extend_comb
  import DataTypes_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  IMM_t            src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  localparam int SH_W = (XLEN == 64) ? 6 : 5;

  logic s;
  logic signed [XLEN-1:0] u_ext;
  logic unused;

  assign s      = instr[31];
  assign u_ext  = $signed({instr[31:12], 12'b0});
  assign unused = ^instr[6:0];

  // Decode the select into one extended immediate.
  always_comb begin
    imm = '0;
    err = 1'b0;
    unique case (1'b1)
      (src == IMM_TypeI):
        imm = {{(XLEN-12){s}}, instr[31:20]};
      (src == IMM_TypeIu):
        imm = {{(XLEN-12){1'b0}}, instr[31:20]};
      (src == IMM_TypeS):
        imm = {{(XLEN-12){s}}, instr[31:25],
               instr[11:7]};
      (src == IMM_TypeB):
        imm = {{(XLEN-13){s}}, s, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      (src == IMM_TypeBu):
        imm = {{(XLEN-13){1'b0}}, s, instr[7],
               instr[30:25], instr[11:8], 1'b0};
      (src == IMM_TypeU):
        imm = u_ext;
      (src == IMM_TypeJ):
        imm = {{(XLEN-21){s}}, s, instr[19:12],
               instr[20], instr[30:21], 1'b0};
      (src == IMM_TypeZ):
        imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      (src == IMM_TypeSh):
        imm = {{(XLEN-SH_W){1'b0}},
               instr[20+SH_W-1:20]};
      default: begin
        imm = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with valid/ready handshake.
// SKID=1 adds a second entry so in_ready is a flop.
module imm_extend_pipe
  import DataTypes_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 4,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  IMM_t             in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [XLEN-1:0] imm_c;
  logic            err_c;
  logic            in_x;
  logic            out_x;

  imm_extend_comb #(.XLEN(XLEN)) u_comb (
    .instr (in_instr),
    .src   (in_imm_src),
    .imm   (imm_c),
    .err   (err_c)
  );

  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    skid_st_t        st;
    logic            rdy_q;
    logic [XLEN-1:0] s_imm;
    logic [TAG_W-1:0] s_tag;
    logic            s_err;

    assign in_ready = rdy_q;

    // Two-entry FIFO: out reg is the head, skid is the tail.
    always_ff @(posedge clk) begin
      if (rst) begin
        st        <= SK_EMPTY;
        rdy_q     <= 1'b0;
        out_valid <= 1'b0;
        out_imm   <= '0;
        out_tag   <= '0;
        out_err   <= 1'b0;
        s_imm     <= '0;
        s_tag     <= '0;
        s_err     <= 1'b0;
      end else begin
        rdy_q <= 1'b1;
        unique case (st)
          SK_EMPTY: begin
            if (in_x) begin
              out_imm   <= imm_c;
              out_tag   <= in_tag;
              out_err   <= err_c;
              out_valid <= 1'b1;
              st        <= SK_ONE;
            end
          end
          SK_ONE: begin
            if (in_x && !out_x) begin
              s_imm <= imm_c;
              s_tag <= in_tag;
              s_err <= err_c;
              st    <= SK_TWO;
              rdy_q <= 1'b0;
            end else if (out_x && !in_x) begin
              out_valid <= 1'b0;
              st        <= SK_EMPTY;
            end else if (in_x && out_x) begin
              out_imm <= imm_c;
              out_tag <= in_tag;
              out_err <= err_c;
            end
          end
          SK_TWO: begin
            if (out_x) begin
              out_imm <= s_imm;
              out_tag <= s_tag;
              out_err <= s_err;
              st      <= SK_ONE;
            end else begin
              rdy_q <= 1'b0;
            end
          end
          default: begin
            out_valid <= 1'b0;
            st        <= SK_EMPTY;
          end
        endcase
      end
    end
  end else begin : g_reg
    logic rdy_q;

    assign in_ready = rdy_q & (~out_valid | out_ready);

    // Single output register reloaded on every accept.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdy_q     <= 1'b0;
        out_valid <= 1'b0;
        out_imm   <= '0;
        out_tag   <= '0;
        out_err   <= 1'b0;
      end else begin
        rdy_q <= 1'b1;
        if (in_x) begin
          out_imm   <= imm_c;
          out_tag   <= in_tag;
          out_err   <= err_c;
          out_valid <= 1'b1;
        end else if (out_x) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32/SKID=1 and XLEN=64/SKID=0.
// Directed vectors plus a randomized scoreboard run.
module tb_imm_extend_pipe;
  import DataTypes_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready;
  logic [31:0] a_in_instr;
  IMM_t        a_in_imm_src;
  logic [3:0]  a_in_tag;
  logic        a_out_valid, a_out_ready;
  logic [31:0] a_out_imm;
  logic [3:0]  a_out_tag;
  logic        a_out_err;

  logic        b_in_valid, b_in_ready;
  logic [31:0] b_in_instr;
  IMM_t        b_in_imm_src;
  logic [3:0]  b_in_tag;
  logic        b_out_valid, b_out_ready;
  logic [63:0] b_out_imm;
  logic [3:0]  b_out_tag;
  logic        b_out_err;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe #(.XLEN(32), .TAG_W(4), .SKID(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_imm_src(a_in_imm_src),
    .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_imm(a_out_imm), .out_tag(a_out_tag),
    .out_err(a_out_err)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(4), .SKID(0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_imm_src(b_in_imm_src),
    .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_imm(b_out_imm), .out_tag(b_out_tag),
    .out_err(b_out_err)
  );

  function automatic longint sx(longint x, int bits);
    longint h;
    h = longint'(1) << (bits - 1);
    return (x >= h) ? x - 2 * h : x;
  endfunction

  function automatic exp_t model(int xlen, logic [31:0] i,
                                 logic [3:0] src,
                                 logic [3:0] tag);
    exp_t   e;
    longint v;
    longint bf;
    e.err = 1'b0;
    bf = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0});
    case (src)
      4'd0: v = sx(longint'(i[31:20]), 12);
      4'd1: v = longint'(i[31:20]);
      4'd2: v = sx(longint'({i[31:25], i[11:7]}), 12);
      4'd3: v = sx(bf, 13);
      4'd4: v = bf;
      4'd5: v = sx(longint'(i[31:12]), 20) * 4096;
      4'd6: v = sx(longint'({i[31], i[19:12], i[20],
                             i[30:21], 1'b0}), 21);
      4'd7: v = longint'(i[19:15]);
      4'd8: v = (xlen == 32) ? longint'(i[24:20])
                             : longint'(i[25:20]);
      default: begin
        v = 0;
        e.err = 1'b1;
      end
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    e.imm = v;
    e.tag = tag;
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 ||
        a_out_imm !== '0 || a_out_tag !== '0 ||
        a_out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: v=%b rdy=%b imm=%h tag=%h err=%b want 0",
               a_out_valid, a_in_ready, a_out_imm, a_out_tag, a_out_err);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0 ||
        b_out_imm !== '0 || b_out_tag !== '0 ||
        b_out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: v=%b rdy=%b imm=%h tag=%h err=%b want 0",
               b_out_valid, b_in_ready, b_out_imm, b_out_tag, b_out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: a=%b b=%b want 1 1",
               a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_vectors_32();
    logic [31:0] vi [6] = '{32'hFFF00093, 32'hFE112E23,
                            32'hFE000EE3, 32'hFE000EE3,
                            32'hFFFFFFFF, 32'h00100093};
    IMM_t vs [6] = '{IMM_TypeI, IMM_TypeS, IMM_TypeB,
                     IMM_TypeBu, IMM_t'(4'hF), IMM_TypeI};
    logic [31:0] vx [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC,
                            32'hFFFFFFFC, 32'h00001FFC,
                            32'h0, 32'h1};
    logic ve [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a_out_ready  = 1'b1;
      a_in_valid   = 1'b1;
      a_in_instr   = vi[k];
      a_in_imm_src = vs[k];
      a_in_tag     = 4'(k + 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_imm !== vx[k] ||
          a_out_err !== ve[k] || a_out_tag !== 4'(k + 1)) begin
        errors++;
        $display("FAIL vec32_%0d: v=%b imm=%h err=%b tag=%h want 1 %h %b %h",
                 k, a_out_valid, a_out_imm, a_out_err, a_out_tag,
                 vx[k], ve[k], 4'(k + 1));
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_vectors_64();
    logic [31:0] vi [4] = '{32'h800000B7, 32'h03F09093,
                            32'h3407D073, 32'hFFF00093};
    IMM_t vs [4] = '{IMM_TypeU, IMM_TypeSh, IMM_TypeZ,
                     IMM_TypeI};
    logic [63:0] vx [4] = '{64'hFFFFFFFF80000000, 64'h3F,
                            64'h0F, 64'hFFFFFFFFFFFFFFFF};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b_out_ready  = 1'b1;
      b_in_valid   = 1'b1;
      b_in_instr   = vi[k];
      b_in_imm_src = vs[k];
      b_in_tag     = 4'(k + 8);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      checks++;
      if (b_out_valid !== 1'b1 || b_out_imm !== vx[k] ||
          b_out_err !== 1'b0 || b_out_tag !== 4'(k + 8)) begin
        errors++;
        $display("FAIL vec64_%0d: v=%b imm=%h err=%b tag=%h want 1 %h 0 %h",
                 k, b_out_valid, b_out_imm, b_out_err, b_out_tag,
                 vx[k], 4'(k + 8));
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0] got[$];
    logic in_x, out_x;
    @(negedge clk);
    a_out_ready  = 1'b0;
    a_in_valid   = 1'b1;
    a_in_instr   = 32'h00100093;
    a_in_imm_src = IMM_TypeI;
    a_in_tag     = 4'd1;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 4'd1 ||
        a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: v=%b tag=%h rdy=%b want 1 1 1",
               a_out_valid, a_out_tag, a_in_ready);
    end
    a_in_tag = 4'd2;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_tag !== 4'd1) begin
      errors++;
      $display("FAIL b2b_two: rdy=%b tag=%h want 0 1",
               a_in_ready, a_out_tag);
    end
    a_in_tag = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_tag !== 4'd1 ||
        a_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: rdy=%b tag=%h v=%b want 0 1 1",
               a_in_ready, a_out_tag, a_out_valid);
    end
    a_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_x  = a_in_valid && a_in_ready;
      out_x = a_out_valid && a_out_ready;
      if (out_x) got.push_back(a_out_tag);
      @(posedge clk); #1;
      if (in_x) a_in_valid = 1'b0;
    end
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d tags want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== 4'(k + 1)) begin
          errors++;
          $display("FAIL b2b_order_%0d: got %h want %h",
                   k, got[k], 4'(k + 1));
        end
      end
    end
  endtask

  task automatic test_reset_in_two();
    @(negedge clk);
    a_out_ready  = 1'b0;
    a_in_valid   = 1'b1;
    a_in_instr   = 32'hFFF00093;
    a_in_imm_src = IMM_TypeI;
    a_in_tag     = 4'd5;
    repeat (2) @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst2_fill: rdy=%b want 0", a_in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 ||
        a_out_tag !== 4'd0) begin
      errors++;
      $display("FAIL rst2_during: v=%b rdy=%b tag=%h want 0 0 0",
               a_out_valid, a_in_ready, a_out_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst2_after: rdy=%b v=%b want 1 0",
               a_in_ready, a_out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst2_stale_%0d: v=%b want 0", c, a_out_valid);
      end
    end
  endtask

  task automatic test_random();
    exp_t qa[$];
    exp_t qb[$];
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== (qa.size() != 0)) begin
        errors++;
        $display("FAIL rand_a_valid@%0d: got %b want %b",
                 n, a_out_valid, qa.size() != 0);
      end else if (qa.size() != 0) begin
        checks++;
        if (a_out_imm !== qa[0].imm[31:0] ||
            a_out_tag !== qa[0].tag ||
            a_out_err !== qa[0].err) begin
          errors++;
          $display("FAIL rand_a_data@%0d: got %h/%h/%b want %h/%h/%b",
                   n, a_out_imm, a_out_tag, a_out_err,
                   qa[0].imm[31:0], qa[0].tag, qa[0].err);
        end
      end
      checks++;
      if (a_in_ready !== (qa.size() < 2)) begin
        errors++;
        $display("FAIL rand_a_ready@%0d: got %b want %b",
                 n, a_in_ready, qa.size() < 2);
      end
      checks++;
      if (b_out_valid !== (qb.size() != 0)) begin
        errors++;
        $display("FAIL rand_b_valid@%0d: got %b want %b",
                 n, b_out_valid, qb.size() != 0);
      end else if (qb.size() != 0) begin
        checks++;
        if (b_out_imm !== qb[0].imm ||
            b_out_tag !== qb[0].tag ||
            b_out_err !== qb[0].err) begin
          errors++;
          $display("FAIL rand_b_data@%0d: got %h/%h/%b want %h/%h/%b",
                   n, b_out_imm, b_out_tag, b_out_err,
                   qb[0].imm, qb[0].tag, qb[0].err);
        end
      end
      a_in_valid   = 1'($urandom_range(0, 1));
      a_in_instr   = $urandom;
      a_in_imm_src = IMM_t'(4'($urandom_range(0, 15)));
      a_in_tag     = 4'($urandom);
      a_out_ready  = ($urandom_range(0, 3) != 0);
      b_in_valid   = 1'($urandom_range(0, 1));
      b_in_instr   = $urandom;
      b_in_imm_src = IMM_t'(4'($urandom_range(0, 15)));
      b_in_tag     = 4'($urandom);
      b_out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (b_in_ready !== (qb.size() == 0 || b_out_ready)) begin
        errors++;
        $display("FAIL rand_b_ready@%0d: got %b want %b",
                 n, b_in_ready, qb.size() == 0 || b_out_ready);
      end
      if (a_out_valid && a_out_ready) void'(qa.pop_front());
      if (a_in_valid && a_in_ready)
        qa.push_back(model(32, a_in_instr, a_in_imm_src, a_in_tag));
      if (b_out_valid && b_out_ready) void'(qb.pop_front());
      if (b_in_valid && b_in_ready)
        qb.push_back(model(64, b_in_instr, b_in_imm_src, b_in_tag));
    end
    @(negedge clk);
    a_in_valid  = 1'b0;
    b_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    a_in_valid   = 1'b0;
    a_in_instr   = '0;
    a_in_imm_src = IMM_TypeI;
    a_in_tag     = '0;
    a_out_ready  = 1'b0;
    b_in_valid   = 1'b0;
    b_in_instr   = '0;
    b_in_imm_src = IMM_TypeI;
    b_in_tag     = '0;
    b_out_ready  = 1'b0;
    test_reset();
    test_vectors_32();
    test_vectors_64();
    test_back_to_back();
    test_reset_in_two();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate generator for the RV32I/RV64I datapath.
- Accepts a 32-bit instruction word plus an immediate-type select over a valid/ready handshake.
- Produces the XLEN-wide extended immediate, a pass-through tag, and an illegal-select flag on a valid/ready output.
- Sits between instruction-register capture and the ALU operand muxes. Optional skid stage so in_ready is a pure register output.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
TAG_W, 4, width of opaque sideband tag carried alongside the immediate
SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single output register

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction/select presented
in_ready  out  1  block can accept this cycle
in_instr  in  32  raw instruction word
in_imm_src  in  IMM_t  immediate type select
in_tag  in  TAG_W  sideband, returned unchanged
out_valid  out  1  out_* fields valid
out_ready  in  1  consumer accepts this cycle
out_imm  out  XLEN  extended immediate
out_tag  out  TAG_W  tag of the accepted input
out_err  out  1  in_imm_src was not a legal encoding

Behaviour:
- Reset, while rst=1 at a clk edge: out_valid=0, out_imm=0, out_tag=0, out_err=0, skid entry empty.
  - in_ready=0 during the reset cycle; in_ready=1 the cycle after.
  - In-flight data is discarded; no partial output after reset.
- Transfer rules:
  - An input transfer occurs on an edge with in_valid&in_ready.
  - An output transfer occurs on an edge with out_valid&out_ready.
  - out_* are stable while out_valid=1 and out_ready=0.
- Latency and throughput: 1 cycle from input transfer to out_valid; 1 result per cycle when out_ready is held high.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational path from out_ready).
  - Simultaneous input and output transfer: the register reloads, and out_valid stays 1.
- SKID=1:
  - States EMPTY (out_valid=0), ONE (out reg full, skid empty), TWO (both full).
  - in_ready = (state != TWO), registered.
  - EMPTY + in xfer -> ONE.
  - ONE + in xfer, no out xfer -> TWO (new data goes to the skid entry).
  - ONE + out xfer, no in xfer -> EMPTY.
  - ONE + both -> ONE (out reg reloads).
  - TWO + out xfer -> ONE (skid moves to the out reg). in_valid is ignored in TWO.
  - Ordering is strictly FIFO.
- Extension. Bits above the stated field fill with the sign (S) or zeros (Z):
  - TypeI: in[31:20], S.
  - TypeIu: in[31:20], Z.
  - TypeS: {in[31:25],in[11:7]}, S.
  - TypeB: {in[31],in[7],in[30:25],in[11:8],0}, S.
  - TypeBu: same field as TypeB, Z.
  - TypeU: {in[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
  - TypeJ: {in[31],in[19:12],in[20],in[30:21],0}, S.
  - TypeZ (new, CSR uimm): in[19:15], Z.
  - TypeSh (new, shift amount): in[24:20] when XLEN=32, in[25:20] when XLEN=64, Z.
- Illegal select: any other in_imm_src value gives out_imm=0 and out_err=1. It is still a normal transfer and does not stall.
- out_err is registered with its own entry; it is not sticky.

Decomposition:
- DataTypes_pkg:
  - extend IMM_t with IMM_TypeZ and IMM_TypeSh; fix the enum width at 4 bits to leave room.
  - add localparam XLEN_DEFAULT=32.
- Sub-module imm_extend_comb: the pure combinational field select/extend, parametrised by XLEN, with outputs imm and err. imm_extend_pipe instantiates it once and owns the handshake, the state and the registers.

Test Plan:
- XLEN=32, TypeI, 0xFFF00093 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_err=0.
- TypeS 0xFE112E23 -> 0xFFFFFFFC. TypeB 0xFE000EE3 -> 0xFFFFFFFC. TypeBu 0xFE000EE3 -> 0x00001FFC.
- XLEN=64, TypeU 0x800000B7 -> 0xFFFFFFFF80000000.
- XLEN=64, TypeSh 0x03F09093 -> 0x3F.
- XLEN=64, TypeZ 0x3407D073 -> 0x0F.
- SKID=1, 3 back-to-back inputs with tags 1,2,3 and out_ready=0:
  - state reaches TWO and in_ready=0 on the cycle after the second accept; the third input is held.
  - raise out_ready: tags emerge 1,2,3 in order, with no drops and no duplicates.
- Illegal in_imm_src=4'hF with instr 0xFFFFFFFF -> out_imm=0, out_err=1. The following legal TypeI 0x00100093 -> out_imm=1, out_err=0.
- Assert rst while in state TWO -> next cycle out_valid=0 and in_ready=0. The cycle after, in_ready=1 and no stale output ever appears.
